// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared state, opcode and branch-condition codes
package control_unit_pkg;

    typedef enum logic [2:0] {
        S_PCRST  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LOAD   = 3'd3,
        S_STORE  = 3'd4,
        S_BRANCH = 3'd5,
        S_ALU    = 3'd6
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_ALU    = 2'b11;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_N      = 3'b010;
    localparam logic [2:0] COND_N_OR_Z = 3'b011;
    localparam logic [2:0] COND_NEVER  = 3'b100;
    localparam logic [2:0] COND_NOT_Z  = 3'b101;
    localparam logic [2:0] COND_NOT_N  = 3'b110;
    localparam logic [2:0] COND_POS    = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch-condition decode
module branch_cond
    import control_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    // Map the condition code and current flags onto a taken decision.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = z;
            COND_N:      taken = n;
            COND_N_OR_Z: taken = n | z;
            COND_NEVER:  taken = 1'b0;
            COND_NOT_Z:  taken = ~z;
            COND_NOT_N:  taken = ~n;
            COND_POS:    taken = ~n & ~z;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control FSM with retired-instruction counter
module control_unit
    import control_unit_pkg::*;
#(
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [1:0]        ir_op,
    input  logic [2:0]        ir_cond,
    input  logic              flag_z,
    input  logic              flag_n,
    output logic              ld_ir,
    output logic              ld_rdir,
    output logic              ld_pc,
    output logic              mem_w,
    output logic              mux_1_pc,
    output logic              reset_pc_sel,
    output logic              ld_reg,
    output logic              ld_flags,
    output logic              reg_src,
    output logic [2:0]        state,
    output logic [ICNT_W-1:0] instr_count
);

    state_t state_q;
    state_t state_d;
    logic   br_taken;

    branch_cond u_branch_cond (
        .cond  (ir_cond),
        .z     (flag_z),
        .n     (flag_n),
        .taken (br_taken)
    );

    assign state = state_q;

    // State register; reset forces S_PCRST immediately so its decode appears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PCRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Count every IR load, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (ld_ir) begin
            instr_count <= instr_count + {{(ICNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and control decode; the fetch enables are held off while run is low.
    always_comb begin
        state_d      = S_PCRST;
        ld_ir        = 1'b0;
        ld_rdir      = 1'b0;
        ld_pc        = 1'b0;
        mem_w        = 1'b0;
        mux_1_pc     = 1'b0;
        reset_pc_sel = 1'b0;
        ld_reg       = 1'b0;
        ld_flags     = 1'b0;
        reg_src      = 1'b0;
        case (state_q)
            S_PCRST: begin
                reset_pc_sel = 1'b1;
                ld_pc        = 1'b1;
                state_d      = S_FETCH;
            end
            S_FETCH: begin
                if (run) begin
                    ld_ir   = 1'b1;
                    ld_pc   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ld_rdir = 1'b1;
                case (ir_op)
                    OP_LOAD:   state_d = S_LOAD;
                    OP_STORE:  state_d = S_STORE;
                    OP_BRANCH: state_d = S_BRANCH;
                    default:   state_d = S_ALU;
                endcase
            end
            S_LOAD: begin
                mux_1_pc = 1'b1;
                ld_reg   = 1'b1;
                ld_flags = 1'b1;
                state_d  = S_FETCH;
            end
            S_STORE: begin
                mux_1_pc = 1'b1;
                mem_w    = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // A taken branch fetches its target here, so it goes straight to decode.
                if (br_taken) begin
                    mux_1_pc = 1'b1;
                    ld_ir    = 1'b1;
                    ld_pc    = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ALU: begin
                ld_reg   = 1'b1;
                reg_src  = 1'b1;
                ld_flags = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_PCRST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
`timescale 1ns/1ps
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [1:0]  ir_op;
    logic [2:0]  ir_cond;
    logic        flag_z;
    logic        flag_n;
    logic        ld_ir;
    logic        ld_rdir;
    logic        ld_pc;
    logic        mem_w;
    logic        mux_1_pc;
    logic        reset_pc_sel;
    logic        ld_reg;
    logic        ld_flags;
    logic        reg_src;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int errors;
    int checks;
    int exp_cnt;
    logic [3:0] taken_tbl [8];

    control_unit #(.ICNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .ir_op        (ir_op),
        .ir_cond      (ir_cond),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .ld_ir        (ld_ir),
        .ld_rdir      (ld_rdir),
        .ld_pc        (ld_pc),
        .mem_w        (mem_w),
        .mux_1_pc     (mux_1_pc),
        .reset_pc_sel (reset_pc_sel),
        .ld_reg       (ld_reg),
        .ld_flags     (ld_flags),
        .reg_src      (reg_src),
        .state        (state),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("mem_w_ld_reg_excl", {31'd0, mem_w & ld_reg}, 32'd0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 0;
        // bit index {z,n}: 0=z0n0, 1=z0n1, 2=z1n0, 3=z1n1
        taken_tbl[0] = 4'b1111;
        taken_tbl[1] = 4'b1100;
        taken_tbl[2] = 4'b1010;
        taken_tbl[3] = 4'b1110;
        taken_tbl[4] = 4'b0000;
        taken_tbl[5] = 4'b0011;
        taken_tbl[6] = 4'b0101;
        taken_tbl[7] = 4'b0001;

        rst_n = 1'b0; run = 1'b0; ir_op = 2'b00; ir_cond = 3'b000;
        flag_z = 1'b0; flag_n = 1'b0;
        #2;
        check("rst_state", state, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_pc_sel", reset_pc_sel, 1);
        check("rst_ld_pc", ld_pc, 1);
        check("rst_ld_ir", ld_ir, 0);
        check("rst_mem_w", mem_w, 0);

        // LOAD at address 0
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1; ir_op = 2'b00;
        step();
        check("ld_fetch_state", state, 1);
        check("ld_fetch_ld_ir", ld_ir, 1);
        check("ld_fetch_ld_pc", ld_pc, 1);
        check("ld_fetch_mux", mux_1_pc, 0);
        check("ld_fetch_pcsel", reset_pc_sel, 0);
        check("ld_fetch_cnt", instr_count, 0);
        step(); exp_cnt = 1;
        check("ld_dec_state", state, 2);
        check("ld_dec_rdir", ld_rdir, 1);
        check("ld_dec_cnt", instr_count, exp_cnt);
        step();
        check("ld_state", state, 3);
        check("ld_reg", ld_reg, 1);
        check("ld_reg_src", reg_src, 0);
        check("ld_flags", ld_flags, 1);
        check("ld_mux", mux_1_pc, 1);
        check("ld_mem_w", mem_w, 0);
        step();
        check("ld_back_fetch", state, 1);
        check("ld_back_ld_reg", ld_reg, 0);

        // STORE
        ir_op = 2'b01;
        step(); exp_cnt = 2;
        check("st_dec_state", state, 2);
        step();
        check("st_state", state, 4);
        check("st_mem_w", mem_w, 1);
        check("st_mux", mux_1_pc, 1);
        check("st_ld_reg", ld_reg, 0);
        step();
        check("st_after_mem_w", mem_w, 0);
        check("st_after_state", state, 1);

        // BRANCH cond=001 with Z=1 (taken)
        ir_op = 2'b10; ir_cond = 3'b001; flag_z = 1'b1; flag_n = 1'b0;
        step(); exp_cnt = 3;
        step();
        check("brt_state", state, 5);
        check("brt_ld_ir", ld_ir, 1);
        check("brt_ld_pc", ld_pc, 1);
        check("brt_mux", mux_1_pc, 1);
        step(); exp_cnt = 4;
        check("brt_next", state, 2);
        check("brt_cnt", instr_count, exp_cnt);

        // BRANCH cond=001 with Z=0 (not taken), then condition sweep
        step();
        check("brn_state", state, 5);
        flag_z = 1'b0;
        #0.1;
        check("brn_ld_ir", ld_ir, 0);
        check("brn_ld_pc", ld_pc, 0);
        check("brn_mux", mux_1_pc, 0);
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 4; f++) begin
                ir_cond = c[2:0];
                flag_z  = f[1];
                flag_n  = f[0];
                #0.1;
                check($sformatf("cond%0d_z%0d_n%0d", c, f[1], f[0]), ld_ir, taken_tbl[c][f]);
            end
        end
        ir_cond = 3'b001; flag_z = 1'b0; flag_n = 1'b0;
        step();
        check("brn_next", state, 1);
        check("brn_cnt", instr_count, exp_cnt);

        // ALU
        ir_op = 2'b11;
        step(); exp_cnt = 5;
        step();
        check("alu_state", state, 6);
        check("alu_ld_reg", ld_reg, 1);
        check("alu_reg_src", reg_src, 1);
        check("alu_flags", ld_flags, 1);
        check("alu_mux", mux_1_pc, 0);
        step();
        check("alu_next", state, 1);

        // run=0 hold at fetch
        run = 1'b0;
        #1;
        check("hold_ld_ir0", ld_ir, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_state", state, 1);
            check("hold_ld_ir", ld_ir, 0);
            check("hold_ld_pc", ld_pc, 0);
            check("hold_cnt", instr_count, exp_cnt);
        end
        run = 1'b1;
        #1;
        check("resume_ld_ir", ld_ir, 1);
        ir_op = 2'b01;
        step(); exp_cnt = 6;
        check("resume_state", state, 2);
        check("resume_cnt", instr_count, exp_cnt);

        // reset asserted in the middle of a STORE
        step();
        check("rst_st_state", state, 4);
        check("rst_st_mem_w", mem_w, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_mem_w", mem_w, 0);
        check("async_state", state, 0);
        check("async_cnt", instr_count, 0);
        check("async_pcsel", reset_pc_sel, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_state", state, 1);
        check("post_rst_mux", mux_1_pc, 0);
        check("post_rst_ld_ir", ld_ir, 1);
        check("post_rst_cnt", instr_count, 0);
        step();
        check("post_rst_cnt1", instr_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
